// File: rtl/pipeline_sequencer_if.sv
// pipeline_sequencer_if
// Groups the debug commands, the hazard-detection inputs from ID/EX/MEM and
// the pipeline-register enable/flush outputs of the pipeline sequencer.
//   master : the environment (debug unit + datapath) driving commands and
//            hazard inputs and consuming the enables/flushes.
//   slave  : the sequencer itself.
interface pipeline_sequencer_if;
  logic        start;
  logic        step;
  logic        halt_instr;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_MemRead;
  logic [4:0]  ex_rt;
  logic        branch_taken;
  logic        pc_enable;
  logic        ifid_enable;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        pipe_enable;
  logic        running;
  logic        halted;
  logic [31:0] cycle_count;

  modport master (
    output start, step, halt_instr, id_rs, id_rt, id_uses_rt,
           ex_MemRead, ex_rt, branch_taken,
    input  pc_enable, ifid_enable, ifid_flush, idex_flush, exmem_flush,
           pipe_enable, running, halted, cycle_count
  );

  modport slave (
    input  start, step, halt_instr, id_rs, id_rt, id_uses_rt,
           ex_MemRead, ex_rt, branch_taken,
    output pc_enable, ifid_enable, ifid_flush, idex_flush, exmem_flush,
           pipe_enable, running, halted, cycle_count
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
// Run/step/halt sequencer and hazard controller for the five-stage MIPS
// pipeline. Drives the PC and IF/ID enables plus the IF/ID, ID/EX and EX/MEM
// flushes; inserts load-use bubbles, squashes wrong-path instructions on a
// taken branch/jump and drains the pipeline after a HALT leaves ID.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-high reset
//   bus    - pipeline_sequencer_if.slave: debug commands, hazard inputs,
//            enables/flushes, running/halted status, advancing-cycle counter
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  pipeline_sequencer_if.slave         bus
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               org_q, org_d;
  logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [31:0]        cycle_count_q, cycle_count_d;
  logic               running_q, running_d;
  logic               halted_q, halted_d;

  logic lu;
  logic halt_go;
  logic pc_en, ifid_en, ifid_fl, idex_fl, exmem_fl, pipe_en;

  always_comb begin
    lu = bus.ex_MemRead & (bus.ex_rt != 5'd0) &
         ((bus.ex_rt == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rt == bus.id_rt)));
    // HALT only commits when it actually leaves ID this cycle and is not
    // being squashed by a taken branch resolving in MEM.
    halt_go = bus.halt_instr & ~lu & ~bus.branch_taken;

    state_d     = state_q;
    org_d       = org_q;
    drain_cnt_d = drain_cnt_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_fl     = 1'b0;
    idex_fl     = 1'b0;
    exmem_fl    = 1'b0;
    pipe_en     = 1'b0;

    if (state_q == S_RUN || state_q == S_STEP || state_q == S_DRAIN) begin
      pipe_en = 1'b1;
      if (bus.branch_taken) begin
        // IF/ID must load to take its bubble, and fetch redirects to target.
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        ifid_fl  = 1'b1;
        idex_fl  = 1'b1;
        exmem_fl = 1'b1;
      end else if (lu || state_q == S_DRAIN) begin
        // Freeze front end, feed a bubble into EX; back end keeps moving.
        idex_fl = 1'b1;
      end else begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start)     state_d = S_RUN;
        else if (bus.step) state_d = S_STEP;
      end
      S_RUN: begin
        if (halt_go) begin
          state_d     = S_DRAIN;
          org_d       = 1'b1;
          drain_cnt_d = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      S_STEP: begin
        if (halt_go) begin
          state_d     = S_DRAIN;
          org_d       = 1'b0;
          drain_cnt_d = CNT_W'(DRAIN_CYCLES - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        // A taken branch here means the HALT was on the wrong path.
        if (bus.branch_taken)        state_d = org_q ? S_RUN : S_IDLE;
        else if (drain_cnt_q == '0)  state_d = S_HALTED;
        else                         drain_cnt_d = drain_cnt_q - CNT_W'(1);
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase

    cycle_count_d = (pipe_en && cycle_count_q != 32'hFFFF_FFFF) ?
                    cycle_count_q + 32'd1 : cycle_count_q;
    running_d = (state_d == S_RUN);
    halted_d  = (state_d == S_HALTED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      org_q         <= 1'b0;
      drain_cnt_q   <= '0;
      cycle_count_q <= 32'd0;
      running_q     <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      org_q         <= org_d;
      drain_cnt_q   <= drain_cnt_d;
      cycle_count_q <= cycle_count_d;
      running_q     <= running_d;
      halted_q      <= halted_d;
    end
  end

  assign bus.pc_enable   = pc_en;
  assign bus.ifid_enable = ifid_en;
  assign bus.ifid_flush  = ifid_fl;
  assign bus.idex_flush  = idex_fl;
  assign bus.exmem_flush = exmem_fl;
  assign bus.pipe_enable = pipe_en;
  assign bus.running     = running_q;
  assign bus.halted      = halted_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  pipeline_sequencer_if bus();
  pipeline_sequencer #(.DRAIN_CYCLES(DC)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle, 1 run, 2 step, 3 drain, 4 halted.
  int          m_mode;
  bit          m_from_run;
  int          m_left;     // drain cycles still to go, including current
  longint      m_count;

  function automatic bit m_lu();
    return bus.ex_MemRead && bus.ex_rt != 0 &&
           (bus.ex_rt == bus.id_rs || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
  endfunction

  // {pc_en, ifid_en, ifid_fl, idex_fl, exmem_fl, pipe_en, running, halted}
  function automatic logic [7:0] m_outs();
    logic [7:0] o;
    bit adv;
    adv = (m_mode >= 1 && m_mode <= 3);
    o = 8'b0;
    if (adv) begin
      o[2] = 1'b1;
      if (bus.branch_taken)              o[7:3] = 5'b11111;
      else if (m_mode == 3 || m_lu())    o[7:3] = 5'b00010;
      else                               o[7:3] = 5'b11000;
    end
    o[1] = (m_mode == 1);
    o[0] = (m_mode == 4);
    return o;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_from_run = 0; m_left = 0; m_count = 0;
    end else begin
      bit go;
      go = bus.halt_instr && !m_lu() && !bus.branch_taken;
      if (m_mode >= 1 && m_mode <= 3 && m_count < 64'hFFFF_FFFF) m_count++;
      case (m_mode)
        0: if (bus.start) m_mode = 1; else if (bus.step) m_mode = 2;
        1: if (go) begin m_mode = 3; m_from_run = 1; m_left = DC; end
        2: if (go) begin m_mode = 3; m_from_run = 0; m_left = DC; end
           else m_mode = 0;
        3: if (bus.branch_taken) m_mode = m_from_run ? 1 : 0;
           else begin m_left--; if (m_left == 0) m_mode = 4; end
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("outs", {24'd0, bus.pc_enable, bus.ifid_enable, bus.ifid_flush,
                   bus.idex_flush, bus.exmem_flush, bus.pipe_enable,
                   bus.running, bus.halted}, {24'd0, m_outs()});
    check("cycle_count", bus.cycle_count, m_count[31:0]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.start = 0; bus.step = 0; bus.halt_instr = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 0;
    bus.ex_MemRead = 0; bus.ex_rt = 0; bus.branch_taken = 0;
  endtask

  logic [31:0] saved;

  initial begin
    clr();
    #12 reset = 1'b0;
    tick();
    check("rst_running", bus.running, 0);
    check("rst_pc_en", bus.pc_enable, 0);
    check("rst_count", bus.cycle_count, 0);

    // Start -> free run
    bus.start = 1; tick(); bus.start = 0;
    check("run_running", bus.running, 1);
    check("run_enables", {bus.pc_enable, bus.ifid_enable, bus.pipe_enable}, 3'b111);
    repeat (10) tick();
    check("run_count10", bus.cycle_count, 10);

    // Load-use stall
    bus.ex_MemRead = 1; bus.ex_rt = 5; bus.id_rs = 5; #1;
    check("lu_stall", {bus.pc_enable, bus.ifid_enable, bus.idex_flush}, 3'b001);
    tick();
    bus.ex_rt = 0; bus.id_rs = 0; #1;
    check("lu_r0", {bus.pc_enable, bus.idex_flush}, 2'b10);
    tick();
    bus.ex_rt = 5; bus.id_rs = 3; bus.id_rt = 5; bus.id_uses_rt = 0; #1;
    check("lu_rt_unused", {bus.pc_enable, bus.idex_flush}, 2'b10);
    tick();
    bus.id_uses_rt = 1; #1;
    check("lu_rt_used", {bus.pc_enable, bus.idex_flush}, 2'b01);
    tick();
    // Branch beats load-use
    bus.branch_taken = 1; #1;
    check("br_over_lu", {bus.pc_enable, bus.ifid_flush, bus.idex_flush, bus.exmem_flush}, 4'b1111);
    tick(); clr();

    // Halt and drain
    bus.halt_instr = 1; tick(); bus.halt_instr = 0;
    check("drain_c1", {bus.pc_enable, bus.idex_flush, bus.running}, 3'b010);
    repeat (3) tick();
    check("drain_c4_not_halted", bus.halted, 0);
    tick();
    check("halted", bus.halted, 1);
    check("halted_count", bus.cycle_count, 20);
    saved = bus.cycle_count;
    bus.start = 1; tick(); tick(); bus.start = 0;
    check("halted_sticky", {bus.halted, bus.pipe_enable}, 2'b10);
    check("halted_count_hold", bus.cycle_count, saved);

    // Single step x3
    reset = 1; tick(); reset = 0; tick();
    for (int i = 0; i < 3; i++) begin
      bus.step = 1; tick(); bus.step = 0;
      check("step_adv", bus.pipe_enable, 1);
      tick();
      check("step_idle", bus.pipe_enable, 0);
    end
    check("step_count3", bus.cycle_count, 3);

    // Step into HALT, wrong-path: back to IDLE
    bus.step = 1; tick(); bus.step = 0;
    bus.halt_instr = 1; tick(); bus.halt_instr = 0;
    check("step_drain", {bus.pc_enable, bus.idex_flush}, 2'b01);
    bus.branch_taken = 1; tick(); bus.branch_taken = 0;
    check("step_drain_br_idle", {bus.running, bus.pipe_enable}, 2'b00);

    // Run, HALT, branch in drain cycle 1 -> back to RUN
    bus.start = 1; tick(); bus.start = 0;
    bus.halt_instr = 1; tick(); bus.halt_instr = 0;
    bus.branch_taken = 1; #1;
    check("drain_br_flush", {bus.pc_enable, bus.ifid_flush, bus.idex_flush, bus.exmem_flush}, 4'b1111);
    tick(); bus.branch_taken = 0;
    check("drain_br_running", bus.running, 1);

    // Reset in the middle of DRAIN
    bus.halt_instr = 1; tick(); bus.halt_instr = 0; tick();
    reset = 1; #1;
    check("async_rst_outs", {bus.pc_enable, bus.idex_flush, bus.pipe_enable, bus.running, bus.halted}, 5'b0);
    check("async_rst_count", bus.cycle_count, 0);
    tick(); reset = 0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
